ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Three-master bus arbiter for the shared 16-bit AHB-lite style bus that feeds the address mux and the slave-select decoder. It takes bus requests and lock requests from masters 0–2 and grants the bus round-robin. Grant changes only at legal transfer boundaries: fixed-length bursts and locked sequences are never split. It drives the address-mux select (`hmaster`) and the data-phase select (`hmaster_data`) for the write-data and response muxes.

## Interface
Parameters
- `DEFAULT_MASTER`, 0: master parked on the bus when nobody requests (0..2).

Ports
- `hclk`  in  1  bus clock; all state changes on its rising edge
- `hreset`  in  1  synchronous, active-high reset
- `hbusreq_0`, `hbusreq_1`, `hbusreq_2`  in  1 each  bus request from master n
- `hlock_0`, `hlock_1`, `hlock_2`  in  1 each  master n requests a locked (indivisible) sequence
- `htrans`  in  2  transfer type of the current address phase: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- `hburst`  in  3  burst type of the current address phase: SINGLE=000, INCR=001, WRAP4/INCR4=010/011, WRAP8/INCR8=100/101, WRAP16/INCR16=110/111
- `hready`  in  1  slave ready; an address phase is accepted on an edge where `hready`=1
- `hgrant_0`, `hgrant_1`, `hgrant_2`  out  1 each  one-hot grant, registered; equals decode of `hmaster`
- `hmaster`  out  2  address-phase owner; select for the address mux
- `hmaster_data`  out  2  data-phase owner; select for the write-data mux
- `hmastlock`  out  1  current address phase belongs to a locked sequence

## Operation
- Beat counter `beats_left`, 4 bits:
  - Loaded on an accepted NONSEQ: 3 for INCR4/WRAP4, 7 for x8, 15 for x16, 0 for SINGLE/INCR.
  - Decremented on each accepted SEQ while it is nonzero.
  - Holds on BUSY, IDLE and `hready`=0.
- Arbitration point (`arb_open`) on an edge with `hready`=1 and `hlock_<hmaster>`=0 and one of:
  - `htrans`=IDLE;
  - `htrans`=NONSEQ with `hburst` SINGLE or INCR;
  - `htrans`=SEQ with `beats_left`≤1, which covers the last beat of a fixed burst and any INCR beat.
- Never open on BUSY, on `hready`=0, or while the current owner holds its `hlock` high.
- Grant selection at an arbitration point:
  - Search requesters in round-robin order starting at (`hmaster`+1) mod 3 and wrapping back to `hmaster`. The first one with `hbusreq` high wins.
  - The current owner keeps the bus only if no other master requests.
  - If no master requests, the bus parks on `DEFAULT_MASTER`.
- Outside an arbitration point, `hmaster` and the grants hold.
- On any edge with `hready`=1:
  - `hmaster_data` ← `hmaster`, the pre-update value.
  - `hmastlock` ← `hlock` of the master that owns the next address phase.
- With `hready`=0, `hmaster_data` and `hmastlock` hold.
- FSM, 2 bits:
  - PARK: default master owns the bus with no request.
  - OWNED: granted master, unlocked.
  - LOCKED: owner's `hlock` is high.
  - Transitions are evaluated only on `hready`=1 edges.
  - PARK→OWNED on any request.
  - OWNED→LOCKED when the owner raises `hlock`.
  - LOCKED→OWNED or PARK on the first arbitration point after `hlock` drops.
  - OWNED→PARK at an arbitration point with no requests.
- Reset values: `hmaster`=`hmaster_data`=`DEFAULT_MASTER`, `hgrant_<DEFAULT_MASTER>`=1 and the others 0, `hmastlock`=0, `beats_left`=0, state PARK.
- Reset mid-burst or mid-lock aborts at the next edge; `hready` is ignored.

## Timing
- Decision to visible grant: 1 cycle. A request sampled at an arbitration edge appears on `hgrant_*`/`hmaster` immediately after that edge, and the new master drives the next address phase.
- `hmaster_data` lags `hmaster` by exactly one accepted (`hready`=1) address phase.
- Worst-case wait for an unlocked requester: 2 other owners × (16 beats + BUSY/wait cycles).
- Simultaneous events:
  - Request rising on the same edge as an arbitration point is honoured.
  - Owner dropping `hbusreq` mid fixed-length burst does not release the bus before the burst ends.
  - `hlock` and `hbusreq` from different masters on the same edge: the round-robin rule alone decides.

## Test plan
- Reset, then no requests for 5 cycles: `hmaster`=0, `hgrant_0`=1, `hmaster_data`=0, `hmastlock`=0 throughout.
- Round-robin: all three `hbusreq` high, SINGLE NONSEQ each cycle, `hready`=1. Ownership sequence 0→1→2→0→1, one owner per cycle. `hmaster_data` trails by one cycle.
- Fixed burst: master 1 owns, issues INCR8 (NONSEQ + 7 SEQ), master 2 requests at beat 2. Grant moves to 2 only on the edge accepting beat 8. Inserting 2 BUSY cycles and 3 `hready`=0 cycles delays the switch by exactly 5 cycles.
- Lock: master 2 holds `hlock_2`=1 across three SINGLE transfers while 0 and 1 request. `hmaster` stays 2 and `hmastlock`=1. Bus moves to 0 on the first `hready`=1 edge after `hlock_2` drops.
- Wait states: `hready`=0 for 4 cycles at an IDLE with master 1 requesting. No grant change until `hready` returns to 1. Switch occurs on that edge.
- Reset mid-burst: assert `hreset` at beat 3 of an INCR16 by master 2. The next edge gives `hmaster`=0, `beats_left`=0, `hmastlock`=0, state PARK.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Three-master round-robin bus arbiter with burst and lock awareness.
// Grants move only at transfer boundaries; fixed bursts and locked sequences are never split.
module ahb_arbiter #(
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic       hclk,
  input  logic       hreset,
  input  logic       hbusreq_0,
  input  logic       hbusreq_1,
  input  logic       hbusreq_2,
  input  logic       hlock_0,
  input  logic       hlock_1,
  input  logic       hlock_2,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  output logic       hgrant_0,
  output logic       hgrant_1,
  output logic       hgrant_2,
  output logic [1:0] hmaster,
  output logic [1:0] hmaster_data,
  output logic       hmastlock
);

  localparam logic [1:0] DefMaster = 2'(DEFAULT_MASTER);
  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [1:0] {Park, Owned, Locked} state_e;

  state_e      state_q;
  logic [1:0]  master_q, master_d;
  logic [1:0]  masterData_q;
  logic        mastLock_q;
  logic [3:0]  beatsLeft_q, beatsLeft_d;
  logic [2:0]  busReq, lockReq;
  logic [1:0]  cand1, cand2;
  logic        arbOpen, ownerLock, nextLock, anyReq;

  assign busReq  = {hbusreq_2, hbusreq_1, hbusreq_0};
  assign lockReq = {hlock_2, hlock_1, hlock_0};
  assign anyReq  = |busReq;

  function automatic logic bitAt(input logic [2:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] nextIdx(input logic [1:0] m);
    return (m == 2'd2) ? 2'd0 : m + 2'd1;
  endfunction

  // A SEQ with beatsLeft <= 1 is either the final fixed-burst beat or an INCR beat.
  always_comb begin
    ownerLock = bitAt(lockReq, master_q);
    arbOpen   = 1'b0;
    if (hready && !ownerLock) begin
      case (htrans)
        TransIdle:   arbOpen = 1'b1;
        TransNonseq: arbOpen = (hburst == 3'b000) || (hburst == 3'b001);
        TransSeq:    arbOpen = (beatsLeft_q <= 4'd1);
        default:     arbOpen = 1'b0;
      endcase
    end
  end

  always_comb begin
    cand1    = nextIdx(master_q);
    cand2    = nextIdx(cand1);
    master_d = master_q;
    if (arbOpen) begin
      if (bitAt(busReq, cand1))         master_d = cand1;
      else if (bitAt(busReq, cand2))    master_d = cand2;
      else if (bitAt(busReq, master_q)) master_d = master_q;
      else                              master_d = DefMaster;
    end
    nextLock = bitAt(lockReq, master_d);
  end

  always_comb begin
    beatsLeft_d = beatsLeft_q;
    if (hready) begin
      if (htrans == TransNonseq) begin
        case (hburst)
          3'b010, 3'b011: beatsLeft_d = 4'd3;
          3'b100, 3'b101: beatsLeft_d = 4'd7;
          3'b110, 3'b111: beatsLeft_d = 4'd15;
          default:        beatsLeft_d = 4'd0;
        endcase
      end else if (htrans == TransSeq && beatsLeft_q != 4'd0) begin
        beatsLeft_d = beatsLeft_q - 4'd1;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= Park;
      master_q     <= DefMaster;
      masterData_q <= DefMaster;
      mastLock_q   <= 1'b0;
      beatsLeft_q  <= 4'd0;
    end else begin
      master_q    <= master_d;
      beatsLeft_q <= beatsLeft_d;
      if (hready) begin
        masterData_q <= master_q;
        mastLock_q   <= nextLock;
        case (state_q)
          Park:    if (anyReq) state_q <= Owned;
          Owned: begin
            if (ownerLock)            state_q <= Locked;
            else if (arbOpen && !anyReq) state_q <= Park;
          end
          Locked:  if (arbOpen) state_q <= anyReq ? Owned : Park;
          default: state_q <= Park;
        endcase
      end
    end
  end

  assign hmaster      = master_q;
  assign hmaster_data = masterData_q;
  assign hmastlock    = mastLock_q;
  assign hgrant_0     = (master_q == 2'd0);
  assign hgrant_1     = (master_q == 2'd1);
  assign hgrant_2     = (master_q == 2'd2);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed table-driven bench for ahb_arbiter: each record is one clock of inputs plus
// the owner, data-phase owner and lock flag expected right after that edge.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR8 = 3'b101, INCR16 = 3'b111;

  logic       hclk = 1'b0;
  logic       hreset;
  logic       hbusreq_0, hbusreq_1, hbusreq_2;
  logic       hlock_0, hlock_1, hlock_2;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic       hgrant_0, hgrant_1, hgrant_2;
  logic [1:0] hmaster, hmaster_data;
  logic       hmastlock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [1:0] expMaster;
    logic [1:0] expData;
    logic       expLock;
    string      name;
  } vec_t;

  vec_t vecs[$];

  ahb_arbiter #(.DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hreset(hreset),
    .hbusreq_0(hbusreq_0), .hbusreq_1(hbusreq_1), .hbusreq_2(hbusreq_2),
    .hlock_0(hlock_0), .hlock_1(hlock_1), .hlock_2(hlock_2),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant_0(hgrant_0), .hgrant_1(hgrant_1), .hgrant_2(hgrant_2),
    .hmaster(hmaster), .hmaster_data(hmaster_data), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  function automatic vec_t mk(input logic rst, input logic [2:0] req, input logic [2:0] lock,
                              input logic [1:0] trans, input logic [2:0] burst, input logic rdy,
                              input logic [1:0] m, input logic [1:0] md, input logic ml,
                              input string name);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.rdy = rdy;
    v.expMaster = m; v.expData = md; v.expLock = ml; v.name = name;
    return v;
  endfunction

  // Drive on the falling edge, let one rising edge pass, then sample 1ns later.
  task automatic applyStimulus(input vec_t v);
    @(negedge hclk);
    hreset = v.rst;
    {hbusreq_2, hbusreq_1, hbusreq_0} = v.req;
    {hlock_2, hlock_1, hlock_0} = v.lock;
    htrans = v.trans;
    hburst = v.burst;
    hready = v.rdy;
    @(posedge hclk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [2:0] expGrant;
    expGrant = 3'b001 << v.expMaster;
    checks++;
    if (hmaster !== v.expMaster) begin
      failures++;
      $display("[TB] FAIL %s hmaster: got %0d expected %0d", v.name, hmaster, v.expMaster);
    end
    checks++;
    if (hmaster_data !== v.expData) begin
      failures++;
      $display("[TB] FAIL %s hmaster_data: got %0d expected %0d", v.name, hmaster_data, v.expData);
    end
    checks++;
    if (hmastlock !== v.expLock) begin
      failures++;
      $display("[TB] FAIL %s hmastlock: got %0b expected %0b", v.name, hmastlock, v.expLock);
    end
    checks++;
    if ({hgrant_2, hgrant_1, hgrant_0} !== expGrant) begin
      failures++;
      $display("[TB] FAIL %s hgrant: got %b expected %b", v.name,
               {hgrant_2, hgrant_1, hgrant_0}, expGrant);
    end
  endtask

  initial begin
    hreset = 1'b1;
    {hbusreq_2, hbusreq_1, hbusreq_0} = 3'b000;
    {hlock_2, hlock_1, hlock_0} = 3'b000;
    htrans = IDLE; hburst = SINGLE; hready = 1'b1;

    vecs.push_back(mk(1, 3'b000, 3'b000, IDLE, SINGLE, 1, 0, 0, 0, "reset"));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 3'b000, 3'b000, IDLE, SINGLE, 1, 0, 0, 0, "park_idle"));

    vecs.push_back(mk(0, 3'b111, 3'b000, NONSEQ, SINGLE, 1, 1, 0, 0, "rr_1"));
    vecs.push_back(mk(0, 3'b111, 3'b000, NONSEQ, SINGLE, 1, 2, 1, 0, "rr_2"));
    vecs.push_back(mk(0, 3'b111, 3'b000, NONSEQ, SINGLE, 1, 0, 2, 0, "rr_0"));
    vecs.push_back(mk(0, 3'b111, 3'b000, NONSEQ, SINGLE, 1, 1, 0, 0, "rr_1b"));

    // Master 1 runs INCR8 with 2 BUSY and 3 wait cycles; master 2 requests from beat 2.
    vecs.push_back(mk(0, 3'b010, 3'b000, NONSEQ, INCR8, 1, 1, 1, 0, "burst_b1"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,    INCR8, 1, 1, 1, 0, "burst_b2"));
    vecs.push_back(mk(0, 3'b110, 3'b000, SEQ,    INCR8, 1, 1, 1, 0, "burst_b3"));
    vecs.push_back(mk(0, 3'b110, 3'b000, BUSY,   INCR8, 1, 1, 1, 0, "burst_busy1"));
    vecs.push_back(mk(0, 3'b110, 3'b000, BUSY,   INCR8, 1, 1, 1, 0, "burst_busy2"));
    vecs.push_back(mk(0, 3'b100, 3'b000, SEQ,    INCR8, 1, 1, 1, 0, "burst_b4"));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 3'b100, 3'b000, SEQ, INCR8, 0, 1, 1, 0, "burst_wait"));
    vecs.push_back(mk(0, 3'b100, 3'b000, SEQ,    INCR8, 1, 1, 1, 0, "burst_b5"));
    vecs.push_back(mk(0, 3'b100, 3'b000, SEQ,    INCR8, 1, 1, 1, 0, "burst_b6"));
    vecs.push_back(mk(0, 3'b100, 3'b000, SEQ,    INCR8, 1, 1, 1, 0, "burst_b7"));
    vecs.push_back(mk(0, 3'b100, 3'b000, SEQ,    INCR8, 1, 2, 1, 0, "burst_b8"));

    vecs.push_back(mk(0, 3'b111, 3'b100, NONSEQ, SINGLE, 1, 2, 2, 1, "lock_1"));
    vecs.push_back(mk(0, 3'b111, 3'b100, NONSEQ, SINGLE, 1, 2, 2, 1, "lock_2"));
    vecs.push_back(mk(0, 3'b111, 3'b100, NONSEQ, SINGLE, 1, 2, 2, 1, "lock_3"));
    vecs.push_back(mk(0, 3'b111, 3'b000, IDLE,   SINGLE, 1, 0, 2, 0, "lock_release"));

    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 3'b010, 3'b000, IDLE, SINGLE, 0, 0, 2, 0, "wait_hold"));
    vecs.push_back(mk(0, 3'b010, 3'b000, IDLE, SINGLE, 1, 1, 0, 0, "wait_switch"));
    vecs.push_back(mk(0, 3'b000, 3'b000, IDLE, SINGLE, 1, 0, 1, 0, "park_default"));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Reset in the middle of a locked INCR16, then prove the beat counter was cleared.
    applyStimulus(mk(0, 3'b100, 3'b000, IDLE,   SINGLE, 1, 2, 0, 0, "mid_grant2"));
    checkOutput(mk(0, 3'b100, 3'b000, IDLE,   SINGLE, 1, 2, 0, 0, "mid_grant2"));
    applyStimulus(mk(0, 3'b100, 3'b100, NONSEQ, INCR16, 1, 2, 2, 1, "mid_b1"));
    checkOutput(mk(0, 3'b100, 3'b100, NONSEQ, INCR16, 1, 2, 2, 1, "mid_b1"));
    applyStimulus(mk(0, 3'b100, 3'b100, SEQ,    INCR16, 1, 2, 2, 1, "mid_b2"));
    checkOutput(mk(0, 3'b100, 3'b100, SEQ,    INCR16, 1, 2, 2, 1, "mid_b2"));
    applyStimulus(mk(1, 3'b100, 3'b100, SEQ,    INCR16, 0, 0, 0, 0, "mid_reset"));
    checkOutput(mk(1, 3'b100, 3'b100, SEQ,    INCR16, 0, 0, 0, 0, "mid_reset"));
    applyStimulus(mk(0, 3'b010, 3'b000, SEQ,    INCR16, 1, 1, 0, 0, "post_reset_seq"));
    checkOutput(mk(0, 3'b010, 3'b000, SEQ,    INCR16, 1, 1, 0, 0, "post_reset_seq"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
